// File: rtl/fib_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fib_sched_pkg
// Purpose  : Shared types and constants for the fib_sched scheduler.
//            - state_e   : scheduler FSM states
//            - MAX_N     : largest operand whose Fibonacci value fits in 32 bits
//            - *_DEF     : default requester count and widths
//            - wrap_inc  : modular increment used for round-robin indexing
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package fib_sched_pkg;

  localparam int NREQ_DEF = 4;
  localparam int W_N_DEF  = 16;
  localparam int W_F_DEF  = 32;

  // F(47) = 2971215073 is the last Fibonacci number below 2^32.
  localparam int MAX_N = 47;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // (base + step) mod modulus, for base/step already below modulus.
  function automatic int wrap_inc(input int base, input int step, input int modulus);
    int s;
    s = base + step;
    if (s >= modulus) s = s - modulus;
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fib_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : fib_sched_if
// Purpose  : Bundles the requester-side and engine-side signals of fib_sched.
// Ports    : (interface signals)
//   req       NREQ       level request per requester
//   req_n     NREQ*W_N   packed operands, slice i belongs to req[i]
//   gnt       NREQ       one-hot current owner of the engine
//   rsp_valid NREQ       one-cycle response pulse on the owner's bit
//   rsp_F     W_F        result, valid with rsp_valid
//   rsp_err   1          range error flag, valid with rsp_valid
//   eng_start 1          one-cycle engine start pulse
//   eng_n     W_N        operand to the engine
//   eng_done  1          one-cycle engine completion pulse
//   eng_F     W_F        engine result
// Modports : slave  - the scheduler (fib_sched)
//            master - the environment (requesters and engine)
// Revision : 1.0 - initial release
// ============================================================================
interface fib_sched_if
  import fib_sched_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int W_N  = W_N_DEF,
  parameter int W_F  = W_F_DEF
);

  logic [NREQ-1:0]     req;
  logic [NREQ*W_N-1:0] req_n;
  logic [NREQ-1:0]     gnt;
  logic [NREQ-1:0]     rsp_valid;
  logic [W_F-1:0]      rsp_F;
  logic                rsp_err;
  logic                eng_start;
  logic [W_N-1:0]      eng_n;
  logic                eng_done;
  logic [W_F-1:0]      eng_F;

  modport slave (
    input  req, req_n, eng_done, eng_F,
    output gnt, rsp_valid, rsp_F, rsp_err, eng_start, eng_n
  );

  modport master (
    output req, req_n, eng_done, eng_F,
    input  gnt, rsp_valid, rsp_F, rsp_err, eng_start, eng_n
  );

endinterface
`default_nettype wire

// File: rtl/fib_sched_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Stateless round-robin pick: first set bit of req_i at or after
//            ptr_i, wrapping past NREQ-1 back to 0.
// Ports    :
//   req_i    in   NREQ    request vector
//   ptr_i    in   W_PTR   highest-priority position
//   valid_o  out  1       any request present
//   mask_o   out  NREQ    one-hot winner (0 when no request)
//   idx_o    out  W_PTR   winner index (0 when no request)
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter
  import fib_sched_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int W_PTR = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [W_PTR-1:0] ptr_i,
  output logic             valid_o,
  output logic [NREQ-1:0]  mask_o,
  output logic [W_PTR-1:0] idx_o
);

  // Scan offsets from farthest to nearest so the nearest set bit to ptr_i
  // is the last assignment and therefore wins.
  always_comb begin
    valid_o = 1'b0;
    mask_o  = '0;
    idx_o   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_i[wrap_inc(int'(ptr_i), k, NREQ)]) begin
        valid_o = 1'b1;
        idx_o   = W_PTR'(wrap_inc(int'(ptr_i), k, NREQ));
        mask_o  = NREQ'(1) << wrap_inc(int'(ptr_i), k, NREQ);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fib_sched.sv
`default_nettype none
// ============================================================================
// Module   : fib_sched
// Purpose  : Round-robin scheduler sharing one iterative Fibonacci engine
//            among NREQ requesters. One transaction at a time:
//            IDLE (arbitrate, latch operand) -> ISSUE (start pulse)
//            -> WAIT (until eng_done) -> RESP (one-cycle response).
// Ports    :
//   clk    in   1   system clock, rising edge
//   reset  in   1   asynchronous reset, active low
//   bus    slave modport of fib_sched_if (requester + engine signals)
// Config   : FIB_RANGE_CHECK_EN - when defined, operands above MAX_N are
//            answered directly with rsp_err=1, rsp_F=0 and the engine is not
//            started; when undefined every operand goes to the engine and
//            rsp_err is constant 0.
// Revision : 1.0 - initial release
// ============================================================================
module fib_sched
  import fib_sched_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int W_N  = W_N_DEF,
  parameter int W_F  = W_F_DEF
) (
  input  logic       clk,
  input  logic       reset,
  fib_sched_if.slave bus
);

  localparam int W_PTR = $clog2(NREQ);

  state_e           state_q, state_d;
  logic [W_PTR-1:0] ptr_q,   ptr_d;
  logic [W_PTR-1:0] owner_q, owner_d;
  logic [NREQ-1:0]  sel_q,   sel_d;    // one-hot form of owner_q
  logic [W_N-1:0]   n_q,     n_d;
  logic [W_F-1:0]   f_q,     f_d;
`ifdef FIB_RANGE_CHECK_EN
  logic             err_q,   err_d;
`endif

  logic             arb_valid;
  logic [NREQ-1:0]  arb_mask;
  logic [W_PTR-1:0] arb_idx;
  logic [W_N-1:0]   win_n;

  rr_arbiter #(
    .NREQ  (NREQ),
    .W_PTR (W_PTR)
  ) u_arb (
    .req_i   (bus.req),
    .ptr_i   (ptr_q),
    .valid_o (arb_valid),
    .mask_o  (arb_mask),
    .idx_o   (arb_idx)
  );

  assign win_n = bus.req_n[int'(arb_idx)*W_N +: W_N];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      sel_q   <= '0;
      n_q     <= '0;
      f_q     <= '0;
`ifdef FIB_RANGE_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      sel_q   <= sel_d;
      n_q     <= n_d;
      f_q     <= f_d;
`ifdef FIB_RANGE_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    sel_d   = sel_q;
    n_d     = n_q;
    f_d     = f_q;
`ifdef FIB_RANGE_CHECK_EN
    err_d   = err_q;
`endif

    case (state_q)
      ST_IDLE: begin
        // The operand is sampled only here; later req_n changes are ignored.
        if (arb_valid) begin
          owner_d = arb_idx;
          sel_d   = arb_mask;
`ifdef FIB_RANGE_CHECK_EN
          err_d   = 1'b0;
          if (win_n > W_N'(MAX_N)) begin
            // Result would not fit in 32 bits: answer without the engine.
            err_d   = 1'b1;
            f_d     = '0;
            state_d = ST_RESP;
          end else begin
            n_d     = win_n;
            state_d = ST_ISSUE;
          end
`else
          n_d     = win_n;
          state_d = ST_ISSUE;
`endif
        end
      end

      ST_ISSUE: begin
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        // eng_done is honoured only here; stray pulses elsewhere are dropped.
        if (bus.eng_done) begin
          f_d     = bus.eng_F;
          state_d = ST_RESP;
        end
      end

      ST_RESP: begin
        ptr_d   = W_PTR'(wrap_inc(int'(owner_q), 1, NREQ));
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // All outputs decode registered state only, so req never reaches gnt
  // combinationally.
  assign bus.eng_start = (state_q == ST_ISSUE);
  assign bus.eng_n     = n_q;
  assign bus.gnt       = (state_q != ST_IDLE) ? sel_q : '0;
  assign bus.rsp_valid = (state_q == ST_RESP) ? sel_q : '0;
  assign bus.rsp_F     = f_q;
`ifdef FIB_RANGE_CHECK_EN
  assign bus.rsp_err   = err_q;
`else
  assign bus.rsp_err   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fib_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_fib_sched
// Purpose  : Self-checking bench for fib_sched. A behavioural engine answers
//            each start with F(n) after a random latency; the expected winner
//            comes from the round-robin rule applied to the request vector.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_fib_sched;

  localparam int NREQ = 4;
  localparam int W_N  = 16;
  localparam int W_F  = 32;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  fib_sched_if #(.NREQ(NREQ), .W_N(W_N), .W_F(W_F)) bus ();

  fib_sched #(.NREQ(NREQ), .W_N(W_N), .W_F(W_F)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int ptr_m    = 0;
  int last_rsp = -1;
  int op [NREQ];

  function automatic logic [63:0] fib(input int n);
    logic [63:0] a, b, t;
    a = 64'd0;
    b = 64'd1;
    for (int i = 0; i < n; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // Round-robin rule: first requester at or after ptr, wrapping.
  function automatic int pick(input logic [NREQ-1:0] r, input int p);
    for (int k = 0; k < NREQ; k++)
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_ops();
    for (int i = 0; i < NREQ; i++) bus.req_n[i*W_N +: W_N] = W_N'(op[i]);
  endtask

  // One full transaction: wait for start, act as engine, check response.
  task automatic serve(input int lat, input logic [NREQ-1:0] drop, output int w);
    int          waited;
    int          exp_w;
    int          exp_n;
    logic [63:0] exp_f;
    w      = -1;
    waited = 0;
    exp_w  = pick(bus.req, ptr_m);
    do begin
      tick();
      waited++;
    end while (bus.eng_start !== 1'b1 && waited < 20);
    chk("start_latency", 64'(waited), 64'd1);
    if (bus.eng_start !== 1'b1 || exp_w < 0) return;
    w     = exp_w;
    exp_n = op[w];
    chk("issue_gnt", 64'(bus.gnt), 64'(1 << w));
    chk("issue_eng_n", 64'(bus.eng_n), 64'(exp_n));
    // Operand changes after the grant must not reach the engine.
    op[w] = $urandom_range(0, 47);
    set_ops();
    repeat (lat) tick();
    chk("wait_gnt", 64'(bus.gnt), 64'(1 << w));
    chk("wait_eng_n", 64'(bus.eng_n), 64'(exp_n));
    exp_f = fib(exp_n) & 64'hFFFF_FFFF;
    bus.eng_done = 1'b1;
    bus.eng_F    = exp_f[31:0];
    tick();
    bus.eng_done = 1'b0;
    bus.eng_F    = $urandom;
    chk("rsp_valid", 64'(bus.rsp_valid), 64'(1 << w));
    chk("rsp_F", 64'(bus.rsp_F), exp_f);
    chk("rsp_err", 64'(bus.rsp_err), 64'd0);
    chk("rsp_gnt", 64'(bus.gnt), 64'(1 << w));
    chk("rsp_no_start", 64'(bus.eng_start), 64'd0);
    if (last_rsp >= 0) chk("rsp_spacing", 64'(cyc - last_rsp), 64'(lat + 3));
    last_rsp = cyc;
    bus.req = bus.req & ~drop;
    tick();
    chk("rsp_pulse_end", 64'(bus.rsp_valid), 64'd0);
    chk("idle_gnt", 64'(bus.gnt), 64'd0);
    ptr_m = (w + 1) % NREQ;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"},       64'(bus.gnt),       64'd0);
    chk({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'd0);
    chk({tag, "_rsp_F"},     64'(bus.rsp_F),     64'd0);
    chk({tag, "_rsp_err"},   64'(bus.rsp_err),   64'd0);
    chk({tag, "_eng_start"}, 64'(bus.eng_start), 64'd0);
    chk({tag, "_eng_n"},     64'(bus.eng_n),     64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          w;
    int          k;
    logic [NREQ-1:0] vec;

    bus.req      = '0;
    bus.req_n    = '0;
    bus.eng_done = 1'b0;
    bus.eng_F    = '0;
    for (int i = 0; i < NREQ; i++) op[i] = 0;
    reset = 1'b0;
    repeat (3) tick();
    chk_all_zero("reset");
    reset = 1'b1;
    tick();

    // Single request, n=8 -> 21.
    op[0] = 8;
    set_ops();
    bus.req = 4'b0001;
    serve($urandom_range(1, 5), 4'b0001, w);

    // Requester 2, n=15 -> 610.
    op[2] = 15;
    set_ops();
    bus.req = 4'b0100;
    serve($urandom_range(1, 5), 4'b0100, w);

    // Reset returns the pointer to 0 before the fairness run.
    reset = 1'b0;
    tick();
    chk_all_zero("reset2");
    reset = 1'b1;
    ptr_m = 0;
    tick();

    // All four requesting continuously: 0,1,2,3,0 back to back.
    for (int i = 0; i < NREQ; i++) op[i] = $urandom_range(0, 47);
    set_ops();
    bus.req  = 4'b1111;
    last_rsp = -1;
    for (int i = 0; i < 5; i++)
      serve($urandom_range(1, 6), (i == 4) ? 4'b1111 : 4'b0000, w);

    // Bring pointer to 2, then requesters 1 and 3 together: 3 before 1.
    last_rsp = -1;
    bus.req  = 4'b0010;
    serve($urandom_range(1, 4), 4'b0010, w);
    bus.req  = 4'b1010;
    last_rsp = -1;
    serve($urandom_range(1, 4), 4'b1000, w);
    serve($urandom_range(1, 4), 4'b0010, w);

    // Reset while the engine is busy; the late eng_done must be ignored.
    op[0] = $urandom_range(0, 47);
    set_ops();
    bus.req = 4'b0001;
    tick();
    chk("rst_wait_start", 64'(bus.eng_start), 64'd1);
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk_all_zero("rst_async");
    bus.req = '0;
    tick();
    reset = 1'b1;
    ptr_m = 0;
    tick();
    bus.eng_done = 1'b1;
    bus.eng_F    = 32'd123;
    tick();
    bus.eng_done = 1'b0;
    chk_all_zero("stray_done");
    tick();
    chk("stray_done_rsp2", 64'(bus.rsp_valid), 64'd0);
    last_rsp = -1;
    op[0] = $urandom_range(0, 47);
    set_ops();
    bus.req = 4'b0001;
    serve($urandom_range(1, 4), 4'b0001, w);

    // Out-of-range operand.
    op[2] = 50;
    set_ops();
    bus.req  = 4'b0100;
    last_rsp = -1;
`ifdef FIB_RANGE_CHECK_EN
    tick();
    chk("range_no_start", 64'(bus.eng_start), 64'd0);
    chk("range_rsp_valid", 64'(bus.rsp_valid), 64'b0100);
    chk("range_rsp_err", 64'(bus.rsp_err), 64'd1);
    chk("range_rsp_F", 64'(bus.rsp_F), 64'd0);
    chk("range_gnt", 64'(bus.gnt), 64'b0100);
    bus.req = '0;
    tick();
    chk("range_rsp_end", 64'(bus.rsp_valid), 64'd0);
    chk("range_no_start2", 64'(bus.eng_start), 64'd0);
    ptr_m = 3;
`else
    serve($urandom_range(1, 4), 4'b0100, w);
`endif

    // Random request patterns, each requester dropping after its response.
    last_rsp = -1;
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < NREQ; i++) op[i] = $urandom_range(0, 47);
      set_ops();
      vec     = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      bus.req = vec;
      k = 0;
      while (bus.req != '0 && k < NREQ) begin
        w = pick(bus.req, ptr_m);
        serve($urandom_range(1, 6), NREQ'(1 << w), w);
        if (w < 0) bus.req = '0;
        k++;
      end
    end

    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
